// File: rtl/instr_fetch_queue.sv
// Circular instruction queue between fetch and decode.
// Accepts up to two instructions per cycle and presents the oldest two to the decoders.
module instr_fetch_queue #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [1:0]               push_num,
  input  logic [1:0][31:0]         push_pc,
  input  logic [1:0][31:0]         push_instr,
  input  logic [1:0]               push_ex,
  output logic                     push_ready,
  input  logic [1:0]               pop_num,
  output logic [1:0]               pop_valid,
  output logic [1:0][31:0]         pop_pc,
  output logic [1:0][31:0]         pop_instr,
  output logic [1:0]               pop_ex,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ex;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [AW-1:0]   head_p1;
  logic [CW-1:0]   count_next;
  logic [1:0]      push_acc;
  logic [1:0]      pop_req;
  logic [1:0]      pop_eff;
  logic            clear;

  assign clear = rst | flush;

  // Accepted push/pop amounts and next occupancy; pops are clamped to what is held.
  always_comb begin
    push_acc = 2'd0;
    if (push_ready) begin
      push_acc = (push_num == 2'd3) ? 2'd2 : push_num;
    end
    pop_req    = (pop_num == 2'd3) ? 2'd2 : pop_num;
    pop_eff    = (CW'(pop_req) > count) ? count[1:0] : pop_req;
    count_next = count + CW'(push_acc) - CW'(pop_eff);
  end

  // Pointer, occupancy and ready registers; flush behaves exactly like reset here.
  always_ff @(posedge clk) begin
    if (clear) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      push_ready <= 1'b1;
    end else begin
      head       <= head + AW'(pop_eff);
      tail       <= tail + AW'(push_acc);
      count      <= count_next;
      push_ready <= (count_next <= CW'(DEPTH - 2));
    end
  end

  // Entry storage write; contents are never cleared, only the pointers are.
  always_ff @(posedge clk) begin
    if (!clear) begin
      if (push_acc != 2'd0) begin
        mem[tail] <= '{pc: push_pc[0], instr: push_instr[0], ex: push_ex[0]};
      end
      if (push_acc == 2'd2) begin
        mem[tail + AW'(1)] <= '{pc: push_pc[1], instr: push_instr[1], ex: push_ex[1]};
      end
    end
  end

  // Head pair read straight from storage; no push-to-pop bypass.
  always_comb begin
    head_p1      = head + AW'(1);
    pop_valid    = {count >= CW'(2), count >= CW'(1)};
    pop_pc[0]    = mem[head].pc;
    pop_instr[0] = mem[head].instr;
    pop_ex[0]    = mem[head].ex;
    pop_pc[1]    = mem[head_p1].pc;
    pop_instr[1] = mem[head_p1].instr;
    pop_ex[1]    = mem[head_p1].ex;
  end

endmodule
